// File: rtl/pc_sequencer.sv
// Program counter with absolute jump, signed relative branch and call/return
// through a small LIFO return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int OFS_W = 4,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             enable,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic [OFS_W-1:0] offset,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] pc,
  output logic [DW-1:0]    depth,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_INCR   = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_CALL   = 3'd4;
  localparam logic [2:0] OP_RET    = 3'd5;

  function automatic logic signed [WIDTH-1:0] sext(input logic [OFS_W-1:0] v);
    logic signed [OFS_W-1:0] vs;
    vs = signed'(v);
    return WIDTH'(vs);
  endfunction

  logic [WIDTH-1:0] stack [2**AW];
  logic [WIDTH-1:0] pc_nxt;
  logic [DW-1:0]    depth_nxt;
  logic             push, ovf_set, unf_set;
  logic [AW-1:0]    wr_idx, top_idx;
  logic signed [WIDTH-1:0] pc_s, br_sum;

  assign stack_full  = (depth == DW'(DEPTH));
  assign stack_empty = (depth == '0);
  assign wr_idx      = AW'(depth);
  assign top_idx     = AW'(depth - DW'(1));
  assign pc_s        = signed'(pc);
  assign br_sum      = pc_s + sext(offset);
  assign out         = enable ? pc : {WIDTH{1'bz}};

  always_comb begin
    pc_nxt    = pc;
    depth_nxt = depth;
    push      = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (op)
      OP_INCR:   pc_nxt = pc + WIDTH'(1);
      OP_JUMP:   pc_nxt = target;
      OP_BRANCH: pc_nxt = unsigned'(br_sum);
      OP_CALL: begin
        if (stack_full) begin
          ovf_set = 1'b1;
        end else begin
          push      = 1'b1;
          depth_nxt = depth + DW'(1);
          pc_nxt    = target;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          unf_set = 1'b1;
        end else begin
          pc_nxt    = stack[top_idx];
          depth_nxt = depth - DW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc    <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      depth <= depth_nxt;
      // A fresh error event in the clearing cycle keeps the flag set.
      ovf   <= ovf_set | (ovf & ~err_clr);
      unf   <= unf_set | (unf & ~err_clr);
    end
  end

  // Stack data is not reset; depth alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (clr_n && push) stack[wr_idx] <= pc + WIDTH'(1);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer, checked every cycle against
// a queue-based reference model.
module tb_pc_sequencer;

  localparam int WIDTH = 6;
  localparam int DEPTH = 4;
  localparam int OFS_W = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             clr_n = 1'b1;
  logic             enable = 1'b1;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] target = '0;
  logic [OFS_W-1:0] offset = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] pc;
  logic [DW-1:0]    depth;
  logic             stack_full, stack_empty, ovf, unf;

  int total = 0;
  int bad   = 0;

  int m_pc = 0;
  int m_stk[$];
  bit m_ovf = 0, m_unf = 0;

  pc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OFS_W(OFS_W)) dut (
    .clk(clk), .clr_n(clr_n), .enable(enable), .op(op), .target(target),
    .offset(offset), .err_clr(err_clr), .out(out), .pc(pc), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit os = 0, us = 0;
    int ofs;
    if (!clr_n) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    case (op)
      3'd1: m_pc = (m_pc + 1) % 64;
      3'd2: m_pc = target;
      3'd3: begin
        ofs  = (offset >= 8) ? int'(offset) - 16 : int'(offset);
        m_pc = (m_pc + ofs + 64) % 64;
      end
      3'd4: if (m_stk.size() == DEPTH) os = 1;
            else begin m_stk.push_back((m_pc + 1) % 64); m_pc = target; end
      3'd5: if (m_stk.size() == 0) us = 1;
            else m_pc = m_stk.pop_back();
      default: ;
    endcase
    m_ovf = os | (m_ovf & !err_clr);
    m_unf = us | (m_unf & !err_clr);
  endtask

  task automatic compare();
    logic [WIDTH-1:0] zv;
    zv = 'z;
    chk("pc", pc, m_pc);
    chk("depth", depth, m_stk.size());
    chk("stack_full", stack_full, m_stk.size() == DEPTH);
    chk("stack_empty", stack_empty, m_stk.size() == 0);
    chk("ovf", ovf, m_ovf);
    chk("unf", unf, m_unf);
    if (enable) chk("out", out, m_pc[WIDTH-1:0]);
    else        chk("out_z", out, zv);
  endtask

  task automatic step(input int o, input int tg = 0, input int of = 0,
                      input bit rn = 1, input bit ec = 0);
    op = o[2:0]; target = tg[WIDTH-1:0]; offset = of[OFS_W-1:0];
    clr_n = rn; err_clr = ec;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    logic [WIDTH-1:0] zv;
    zv = 'z;
    #1;
    // Scenario 1: reset then 65 increments with wrap
    step(0, 0, 0, 0);
    chk("rst_pc", pc, 0); chk("rst_empty", stack_empty, 1); chk("rst_full", stack_full, 0);
    for (int i = 1; i <= 65; i++) begin
      step(1);
      chk("incr_pc", pc, i % 64);
    end
    // Scenario 2: combinational tri-state output
    step(2, 'h2A);
    enable = 1'b0; #1; chk("out_hiz", out, zv);
    enable = 1'b1; #1; chk("out_2a", out, 'h2A);
    // Scenario 3: branches
    step(2, 2); step(3, 0, 4'b1101); chk("br_neg", pc, 'h3F);
    step(2, 'h3C); step(3, 0, 4'b0111); chk("br_pos", pc, 'h03);
    // Scenario 4: call/return to full and empty
    step(2, 5);
    step(4, 20); step(4, 30); step(4, 40); step(4, 50);
    chk("call_pc", pc, 50); chk("call_depth", depth, 4); chk("call_full", stack_full, 1);
    step(4, 60); chk("ovf_pc", pc, 50); chk("ovf_flag", ovf, 1);
    step(5); chk("ret1", pc, 41);
    step(5); chk("ret2", pc, 31);
    step(5); chk("ret3", pc, 21);
    step(5); chk("ret4", pc, 6); chk("ret_empty", stack_empty, 1);
    step(5); chk("unf_pc", pc, 6); chk("unf_flag", unf, 1);
    // Scenario 5: reset with CALL mid-sequence
    step(0, 0, 0, 0);
    step(4, 1); step(4, 2); step(4, 'h10);
    chk("pre_rst_depth", depth, 3);
    step(4, 5, 0, 0);
    chk("mid_rst_pc", pc, 0); chk("mid_rst_depth", depth, 0); chk("mid_rst_ovf", ovf, 0);
    step(5); chk("post_rst_unf", unf, 1); chk("post_rst_pc", pc, 0);
    // Scenario 6: error clear versus new error
    step(0, 0, 0, 0);
    step(4, 1); step(4, 2); step(4, 3); step(4, 4);
    step(4, 9, 0, 1, 1); chk("clr_vs_set", ovf, 1);
    step(0, 0, 0, 1, 1); chk("clr_ovf", ovf, 0); chk("clr_unf", unf, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int o;
      o = (($urandom % 10) < 6) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 7));
      enable = ($urandom % 8) != 0;
      step(o, $urandom_range(0, 63), $urandom_range(0, 15),
           ($urandom % 60) != 0, ($urandom % 12) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
